ram_shuffler: RTL and testbench

//  RC4 key-scheduling (KSA) shuffle over a 256x8 single-port synchronous RAM already holding S[i]=i.
//  For i=0..255: j=(j+S[i]+key_byte(i mod 3)) mod 256, then swap S[i] and S[j].

---
 rtl/rc4_pkg.sv | 21 ++
 rtl/key_byte_sel.sv | 21 ++
 rtl/ram_shuffler.sv | 160 ++++++++++++++++
 tb/tb_ram_shuffler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling datapath: major state encoding, key width
// and the byte type used throughout.
package rc4_pkg;

  localparam int unsigned KEY_BYTES = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetchI = 2'd1,
    StFetchJ = 2'd2,
    StSwap   = 2'd3
  } state_t;

  // k tracks i mod 3 incrementally, so no divider is ever needed.
  function automatic logic [1:0] next_k(input logic [1:0] k);
    return (k == 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

endpackage

// File: rtl/key_byte_sel.sv
// Selects the key byte used in the current KSA iteration from the mod-3 counter k.
// key[2] serves k==0, key[1] serves k==1, key[0] serves k==2.
module key_byte_sel
  import rc4_pkg::*;
(
  input  logic [KEY_BYTES-1:0][7:0] i_key,
  input  logic [1:0]                i_k,
  output byte_t                     o_key_byte
);

  always_comb begin
    o_key_byte = '0;
    case (i_k)
      2'd0:    o_key_byte = i_key[2];
      2'd1:    o_key_byte = i_key[1];
      2'd2:    o_key_byte = i_key[0];
      default: o_key_byte = '0;
    endcase
  end

endmodule

// File: rtl/ram_shuffler.sv
// RC4 KSA shuffle over a 256x8 single-port synchronous RAM preloaded with S[i]=i.
// Each iteration takes six cycles: fetch S[i], fetch S[j], then write both swapped values.
module ram_shuffler
  import rc4_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  input  byte_t                     ram_out,
  input  logic [KEY_BYTES-1:0][7:0] key,
  output logic                      write_enable,
  output byte_t                     ram_in,
  output byte_t                     address,
  output byte_t                     iTap,
  output byte_t                     jTap,
  output logic [1:0]                stateTap,
  output byte_t                     siTap,
  output byte_t                     sjTap,
  output logic                      readTap,
  output logic                      writeTap
);

  state_t     r_state, w_state_nxt;
  logic       r_phase, w_phase_nxt;
  byte_t      r_i, w_i_nxt;
  byte_t      r_j, w_j_nxt;
  byte_t      r_si, w_si_nxt;
  byte_t      r_sj, w_sj_nxt;
  logic [1:0] r_k, w_k_nxt;
  logic       r_finished, w_finished_nxt;
  byte_t      w_key_byte;

  key_byte_sel u_key_byte_sel (
    .i_key      (key),
    .i_k        (r_k),
    .o_key_byte (w_key_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_phase    <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_k        <= '0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_si       <= w_si_nxt;
      r_sj       <= w_sj_nxt;
      r_k        <= w_k_nxt;
      r_finished <= w_finished_nxt;
    end
  end

  // Phase 0 presents the address; phase 1 consumes the RAM data or issues the second write.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_si_nxt       = r_si;
    w_sj_nxt       = r_sj;
    w_k_nxt        = r_k;
    w_finished_nxt = r_finished;

    case (r_state)
      StIdle: begin
        w_phase_nxt = 1'b0;
        if (start) begin
          w_i_nxt        = '0;
          w_j_nxt        = '0;
          w_k_nxt        = '0;
          w_finished_nxt = 1'b0;
          w_state_nxt    = StFetchI;
        end
      end
      StFetchI: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_si_nxt    = ram_out;
          w_j_nxt     = r_j + ram_out + w_key_byte;
          w_phase_nxt = 1'b0;
          w_state_nxt = StFetchJ;
        end
      end
      StFetchJ: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_sj_nxt    = ram_out;
          w_phase_nxt = 1'b0;
          w_state_nxt = StSwap;
        end
      end
      StSwap: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (r_i == 8'hFF) begin
            w_finished_nxt = 1'b1;
            w_state_nxt    = StIdle;
          end else begin
            w_i_nxt     = r_i + 8'd1;
            w_k_nxt     = next_k(r_k);
            w_state_nxt = StFetchI;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_phase_nxt = 1'b0;
      end
    endcase
  end

  // Moore output decode; S[j] is written first so i==j leaves the original value in place.
  always_comb begin
    address      = '0;
    ram_in       = '0;
    write_enable = 1'b0;
    readTap      = 1'b0;

    case (r_state)
      StFetchI: begin
        address = r_i;
        readTap = ~r_phase;
      end
      StFetchJ: begin
        address = r_j;
        readTap = ~r_phase;
      end
      StSwap: begin
        write_enable = 1'b1;
        address      = r_phase ? r_i : r_j;
        ram_in       = r_phase ? r_sj : r_si;
      end
      default: begin
        address = '0;
      end
    endcase
  end

  assign finished = r_finished;
  assign iTap     = r_i;
  assign jTap     = r_j;
  assign stateTap = r_state;
  assign siTap    = r_si;
  assign sjTap    = r_sj;
  assign writeTap = write_enable;

endmodule

// File: tb/tb_ram_shuffler.sv
// Scoreboard bench for ram_shuffler: a software KSA model queues the expected RAM writes,
// a monitor pops them on every write strobe; directed probes cover timing and reset.
module tb_ram_shuffler;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            finished;
  logic [7:0]      ram_out;
  logic [2:0][7:0] key;
  logic            write_enable;
  logic [7:0]      ram_in;
  logic [7:0]      address;
  logic [7:0]      iTap;
  logic [7:0]      jTap;
  logic [1:0]      stateTap;
  logic [7:0]      siTap;
  logic [7:0]      sjTap;
  logic            readTap;
  logic            writeTap;

  always #5 clk = ~clk;

  ram_shuffler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .finished     (finished),
    .ram_out      (ram_out),
    .key          (key),
    .write_enable (write_enable),
    .ram_in       (ram_in),
    .address      (address),
    .iTap         (iTap),
    .jTap         (jTap),
    .stateTap     (stateTap),
    .siTap        (siTap),
    .sjTap        (sjTap),
    .readTap      (readTap),
    .writeTap     (writeTap)
  );

  // Synchronous single-port RAM, read-before-write, with a bulk-load port for the bench.
  logic [7:0] mem    [256];
  logic [7:0] init_s [256];
  logic       load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_s[a];
    end else if (write_enable) begin
      mem[address] <= ram_in;
    end
    ram_out <= mem[address];
  end

  logic [15:0] exp_q [$];
  logic [7:0]  s_model [256];
  int          n_cmp = 0;
  int          n_err = 0;

  // Monitor: every write strobe must match the next queued {address, data} pair.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset === 1'b1 && write_enable === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                 address, ram_in);
      end else begin
        e = exp_q.pop_front();
        if ({address, ram_in} !== e) begin
          n_err++;
          $display("FAIL write: got addr %0d data %0d, required addr %0d data %0d",
                   address, ram_in, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic load_ram(input bit identity);
    for (int a = 0; a < 256; a++) begin
      init_s[a]  = identity ? a[7:0] : 8'd0;
      s_model[a] = init_s[a];
    end
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  // Software RC4 KSA over the model array, queuing the two writes of each swap.
  task automatic model_run(input logic [23:0] kv);
    int         j;
    logic [7:0] kb;
    logic [7:0] si;
    logic [7:0] sj;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = kv[8*(2 - (i % 3)) +: 8];
      j  = (j + int'(s_model[i]) + int'(kb)) % 256;
      si = s_model[i];
      sj = s_model[j];
      exp_q.push_back({j[7:0], si});
      exp_q.push_back({i[7:0], sj});
      s_model[j] = si;
      s_model[i] = sj;
    end
  endtask

  task automatic accept_start();
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until finished rises, starting from n0, bounded by limit.
  task automatic wait_done(input int n0, input int limit, output int n);
    n = n0;
    while (finished !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (finished !== 1'b1) check("finish_timeout", 0, 1);
  endtask

  task automatic compare_ram(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== s_model[a]) bad++;
    check(nm, bad, 0);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    load_req = 1'b0;
    key      = 24'h000001;
    for (int a = 0; a < 256; a++) init_s[a] = 8'd0;

    #12;
    check("rst_state", stateTap, 0);
    check("rst_finished", finished, 0);
    check("rst_we", write_enable, 0);
    check("rst_addr", address, 0);
    check("rst_i", iTap, 0);
    check("rst_j", jTap, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Zero RAM with key 000001: j advances only on i%3==2 iterations.
    load_ram(1'b0);
    model_run(key);
    accept_start();
    start = 1'b0;
    check("accept_state", stateTap, 1);
    check("accept_read", readTap, 1);
    for (n = 1; n <= 1536; n++) begin
      @(posedge clk);
      #1;
      if (n == 6)    check("j_after_i0", jTap, 0);
      if (n == 12)   check("j_after_i1", jTap, 0);
      if (n == 12)   check("i_at_12", iTap, 2);
      if (n == 18)   check("j_after_i2", jTap, 1);
      if (n == 36)   check("j_after_i5", jTap, 2);
      if (n == 1535) check("not_done_1535", finished, 0);
    end
    check("done_1536", finished, 1);
    check("final_i", iTap, 255);
    check("final_j", jTap, 85);
    check("final_state", stateTap, 0);
    check("drained_t2", exp_q.size(), 0);

    // start held for 170 cycles then dropped mid-run.
    model_run(key);
    accept_start();
    check("restart_clears_finished", finished, 0);
    repeat (169) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(169, 2000, n);
    check("t4_finish_cycle", n, 1536);
    check("drained_t4", exp_q.size(), 0);

    // start held high across completion: immediate restart, second completion 1537 later.
    model_run(key);
    model_run(key);
    accept_start();
    wait_done(0, 2000, n);
    check("t5_first_done", n, 1536);
    @(posedge clk);
    #1;
    check("t5_restart_finished", finished, 0);
    check("t5_restart_state", stateTap, 1);
    wait_done(1, 2000, n);
    start = 1'b0;
    check("t5_second_done", n, 1537);
    check("drained_t5", exp_q.size(), 0);

    // Identity RAM: final contents must equal the software KSA result.
    load_ram(1'b1);
    key = 24'h000001;
    model_run(key);
    accept_start();
    start = 1'b0;
    wait_done(0, 2000, n);
    check("t6_done", n, 1536);
    compare_ram("t6_final_ram");
    check("drained_t6", exp_q.size(), 0);

    repeat (3) begin
      load_ram(1'b1);
      key = 24'($urandom);
      model_run(key);
      accept_start();
      start = 1'b0;
      wait_done(0, 2000, n);
      check("rand_done", n, 1536);
      compare_ram("rand_final_ram");
      check("rand_drained", exp_q.size(), 0);
    end

    // Mid-run reset aborts immediately.
    load_ram(1'b1);
    model_run(key);
    accept_start();
    start = 1'b0;
    repeat ($urandom_range(100, 1400)) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_state", stateTap, 0);
    check("abort_i", iTap, 0);
    check("abort_j", jTap, 0);
    check("abort_finished", finished, 0);
    check("abort_we", write_enable, 0);
    check("abort_addr", address, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_abort_idle", stateTap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
